// File: rtl/sfq_xor_sched_pkg.sv
// rtl/sfq_xor_sched_pkg.sv - shared types and defaults for the SFQ XOR pulse scheduler
// Contents: scheduler state enum, default gap lengths (in scheduler clocks),
// default gap-timer width and statistics counter width.
package sfq_xor_sched_pkg;

   localparam int T_IN_IN_DEF  = 3;
   localparam int T_IN_CLK_DEF = 1;
   localparam int T_OUT_DEF    = 6;
   localparam int CW_DEF       = 4;
   localparam int STAT_W       = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRV_A    = 3'd1,
      GAP_AB   = 3'd2,
      DRV_B    = 3'd3,
      GAP_CLK  = 3'd4,
      DRV_CLK  = 3'd5,
      WAIT_OUT = 3'd6,
      RESP     = 3'd7
   } sched_state_e;

endpackage

// File: rtl/sfq_gap_timer.sv
// rtl/sfq_gap_timer.sv - loadable down-counter used for every inter-pulse gap
// Ports: clk, rst (sync, active-high), load/load_val (start a gap),
// done (count has reached zero).
module sfq_gap_timer #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          done
);

   logic [CW-1:0] cnt;

   // Runs down to zero and parks there; the FSM only looks at done while it
   // sits in a gap state, so the idle decrement is harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/sfq_xor_pulse_scheduler.sv
// rtl/sfq_xor_pulse_scheduler.sv - pulse sequencer driving one mitll_xor RSFQ cell
// Ports: clk, rst (sync, active-high); request req_valid/req_ready/req_a/req_b;
// toggle lines sfq_a/sfq_b/sfq_clk to the cell; sfq_out cell output level;
// result rsp_valid/rsp_data/rsp_err; err_sticky.
// Optional macro SFQ_XOR_SCHED_STATS_EN adds stat_txn/stat_err counters.
module sfq_xor_pulse_scheduler
   import sfq_xor_sched_pkg::*;
#(
   parameter int T_IN_IN  = T_IN_IN_DEF,
   parameter int T_IN_CLK = T_IN_CLK_DEF,
   parameter int T_OUT    = T_OUT_DEF,
   parameter int CW       = CW_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   output logic req_ready,
   input  logic req_a,
   input  logic req_b,
   output logic sfq_a,
   output logic sfq_b,
   output logic sfq_clk,
   input  logic sfq_out,
   output logic rsp_valid,
   output logic rsp_data,
   output logic rsp_err,
   output logic err_sticky
`ifdef SFQ_XOR_SCHED_STATS_EN
  ,output logic [STAT_W-1:0] stat_txn,
   output logic [STAT_W-1:0] stat_err
`endif
);

   generate
      if (T_IN_IN < 1 || T_IN_IN >= (1 << CW) ||
          T_IN_CLK < 1 || T_IN_CLK >= (1 << CW) ||
          T_OUT < 1 || T_OUT >= (1 << CW)) begin : g_bad_timing
         $error("sfq_xor_pulse_scheduler: gap parameters must lie in 1 .. 2**CW-1");
      end
   endgenerate

   // A gap of T cycles is one DRV cycle plus T-1 cycles in the GAP state;
   // the timer counts T-2 .. 0 while in the GAP state.
   localparam logic [CW-1:0] LD_AB  = CW'((T_IN_IN  > 1) ? (T_IN_IN  - 2) : 0);
   localparam logic [CW-1:0] LD_CLK = CW'((T_IN_CLK > 1) ? (T_IN_CLK - 2) : 0);
   localparam logic [CW-1:0] LD_OUT = CW'((T_OUT    > 1) ? (T_OUT    - 2) : 0);

   sched_state_e  state;
   logic          op_a;
   logic          op_b;
   logic          op_par;
   logic          out_exp;
   logic          out_bad;
   logic          tmr_load;
   logic [CW-1:0] tmr_val;
   logic          tmr_done;

   assign op_par  = op_a ^ op_b;
   // Case inequality so that an X/Z cell output is reported as an error.
   assign out_bad = (sfq_out !== out_exp);

   // Timer is loaded on the same edge that enters the matching GAP/WAIT state.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         DRV_A: begin
            if (op_b) begin
               if (T_IN_IN > 1) begin
                  tmr_load = 1'b1;
                  tmr_val  = LD_AB;
               end
            end else if (T_IN_CLK > 1) begin
               tmr_load = 1'b1;
               tmr_val  = LD_CLK;
            end
         end
         DRV_B: begin
            if (T_IN_CLK > 1) begin
               tmr_load = 1'b1;
               tmr_val  = LD_CLK;
            end
         end
         DRV_CLK: begin
            if (T_OUT > 1) begin
               tmr_load = 1'b1;
               tmr_val  = LD_OUT;
            end
         end
         default: ;
      endcase
   end

   sfq_gap_timer #(.CW(CW)) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Every line toggle happens on the edge entering the DRV_* state, so the
   // new level is present during that state's cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         sfq_a      <= 1'b0;
         sfq_b      <= 1'b0;
         sfq_clk    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= 1'b0;
         rsp_err    <= 1'b0;
         err_sticky <= 1'b0;
         out_exp    <= 1'b0;
         op_a       <= 1'b0;
         op_b       <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  op_a      <= req_a;
                  op_b      <= req_b;
                  req_ready <= 1'b0;
                  if (req_a) begin
                     sfq_a <= ~sfq_a;
                     state <= DRV_A;
                  end else if (req_b) begin
                     sfq_b <= ~sfq_b;
                     state <= DRV_B;
                  end else begin
                     // No inputs: clock the cell at once, parity unchanged.
                     sfq_clk <= ~sfq_clk;
                     state   <= DRV_CLK;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            DRV_A: begin
               if (op_b) begin
                  if (T_IN_IN > 1) begin
                     state <= GAP_AB;
                  end else begin
                     sfq_b <= ~sfq_b;
                     state <= DRV_B;
                  end
               end else if (T_IN_CLK > 1) begin
                  state <= GAP_CLK;
               end else begin
                  sfq_clk <= ~sfq_clk;
                  out_exp <= out_exp ^ op_par;
                  state   <= DRV_CLK;
               end
            end
            GAP_AB: begin
               if (tmr_done) begin
                  sfq_b <= ~sfq_b;
                  state <= DRV_B;
               end
            end
            DRV_B: begin
               if (T_IN_CLK > 1) begin
                  state <= GAP_CLK;
               end else begin
                  sfq_clk <= ~sfq_clk;
                  out_exp <= out_exp ^ op_par;
                  state   <= DRV_CLK;
               end
            end
            GAP_CLK: begin
               if (tmr_done) begin
                  sfq_clk <= ~sfq_clk;
                  out_exp <= out_exp ^ op_par;
                  state   <= DRV_CLK;
               end
            end
            DRV_CLK, WAIT_OUT: begin
               if ((state == DRV_CLK && T_OUT == 1) || (state == WAIT_OUT && tmr_done)) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= out_exp;
                  rsp_err   <= out_bad;
                  if (out_bad) begin
                     err_sticky <= 1'b1;
                  end
                  // Follow a known cell state; an unknown sample leaves the model alone.
                  if (!$isunknown(sfq_out) && sfq_out != out_exp) begin
                     out_exp <= sfq_out;
                  end
                  state <= RESP;
               end else if (state == DRV_CLK) begin
                  state <= WAIT_OUT;
               end
            end
            RESP: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SFQ_XOR_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_txn <= '0;
         stat_err <= '0;
      end else if (rsp_valid) begin
         if (stat_txn != '1) begin
            stat_txn <= stat_txn + 1'b1;
         end
         if (rsp_err && stat_err != '1) begin
            stat_err <= stat_err + 1'b1;
         end
      end
   end
`endif

endmodule
